// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, matrix size
// and the (row, col) -> hex code key map.
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_HELD,
      ST_RELEASE
   } state_t;

   // Physical key legend: rows top to bottom, columns left to right.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'h0;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         4'hF: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and result-side signals of the scanner, bundled.
// slave = the scanner itself, master = whoever drives rows / consumes keys.
interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [NUM_ROWS-1:0] row;
   logic [NUM_COLS-1:0] col;
   logic [3:0]          key_code;
   logic                key_valid;
   logic                key_down;

   modport master (output row, input col, input key_code, input key_valid, input key_down);
   modport slave  (input row, output col, output key_code, output key_valid, output key_down);

endinterface

// File: rtl/keypad_encoder.sv
// Classifies one full 16-bit scan record (bit c*4+r, active-low) as
// none / single / multi and returns the code of the pressed key.
module keypad_encoder
   import keypad_pkg::*;
(
   input  logic [15:0] scan,
   output logic        none,
   output logic        single,
   output logic        multi,
   output logic [3:0]  code
);

   logic [4:0] low_cnt;

   // Count low bits and remember the key code of the (last) low bit found.
   always_comb begin
      low_cnt = 5'd0;
      code    = 4'h0;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            if (!scan[c*4 + r]) begin
               low_cnt = low_cnt + 5'd1;
               code    = key_map(2'(r), 2'(c));
            end
         end
      end
   end

   assign none   = (low_cnt == 5'd0);
   assign single = (low_cnt == 5'd1);
   assign multi  = (low_cnt >= 5'd2);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, records the
// row pattern per column, and debounces whole scans into a single press
// strobe plus a held level and the accepted key code.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
)(
   input  logic           clk,
   input  logic           rst,
   keypad_scanner_if.slave kp
);

   localparam int  DIV_W    = $clog2(SCAN_DIV);
   localparam int  DCNT_W   = $clog2(DEBOUNCE_SCANS + 1);
   localparam bit  ONE_SCAN = (DEBOUNCE_SCANS == 1);

   logic [3:0]        row_p0, row_p1;
   logic [DIV_W-1:0]  div_q;
   logic [1:0]        idx_q;
   logic [15:0]       scan_q, scan_now;
   logic [3:0]        col_q;
   logic              tick, scan_done;

   logic              scan_none, scan_single, scan_multi;
   logic [3:0]        scan_code;

   state_t            state_q, state_d;
   logic [3:0]        cand_q, cand_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_down_q, key_down_d;

   function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
      if (int'(v) >= DEBOUNCE_SCANS) return v;
      return v + DCNT_W'(1);
   endfunction

   assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
   assign scan_done = tick && (idx_q == 2'd3);

   // Scan record including the slice being captured this cycle, so the
   // evaluation at scan completion sees all four columns.
   always_comb begin
      scan_now = scan_q;
      scan_now[{idx_q, 2'b00} +: 4] = row_p1;
   end

   keypad_encoder u_enc (
      .scan   (scan_now),
      .none   (scan_none),
      .single (scan_single),
      .multi  (scan_multi),
      .code   (scan_code)
   );

   // Row synchronizer, dwell counter, column sequencing and scan record.
   // The record resets to all-high, i.e. "no key seen".
   always_ff @(posedge clk) begin
      if (!rst) begin
         row_p0 <= 4'hF;
         row_p1 <= 4'hF;
         div_q  <= '0;
         idx_q  <= 2'd0;
         scan_q <= 16'hFFFF;
         col_q  <= 4'b1110;
      end else begin
         // stage p0 -> p1: two-flop synchronizer on the asynchronous rows
         row_p0 <= kp.row;
         row_p1 <= row_p0;
         div_q  <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            scan_q <= scan_now;
            idx_q  <= idx_q + 2'd1;
         end
         col_q <= ~(4'b0001 << idx_q);
      end
   end

   // Debounce FSM state register and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cand_q      <= 4'h0;
         dcnt_q      <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         dcnt_q      <= dcnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
      end
   end

   // Debounce decisions, taken only when a full scan has completed.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      dcnt_d      = dcnt_q;
      dcnt_inc    = sat_inc(dcnt_q);
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      if (scan_done) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_single) begin
                  cand_d = scan_code;
                  dcnt_d = DCNT_W'(1);
                  if (ONE_SCAN) begin
                     key_code_d  = scan_code;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     dcnt_d      = '0;
                     state_d     = ST_HELD;
                  end else begin
                     state_d = ST_CONFIRM;
                  end
               end
            end
            ST_CONFIRM: begin
               if (scan_single && (scan_code == cand_q)) begin
                  dcnt_d = dcnt_inc;
                  if (int'(dcnt_inc) >= DEBOUNCE_SCANS) begin
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     dcnt_d      = '0;
                     state_d     = ST_HELD;
                  end
               end else if (scan_single) begin
                  cand_d = scan_code;
                  dcnt_d = DCNT_W'(1);
               end else begin
                  dcnt_d  = '0;
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (scan_none) begin
                  if (ONE_SCAN) begin
                     key_down_d = 1'b0;
                     dcnt_d     = '0;
                     state_d    = ST_IDLE;
                  end else begin
                     dcnt_d  = DCNT_W'(1);
                     state_d = ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               if (scan_none) begin
                  dcnt_d = dcnt_inc;
                  if (int'(dcnt_inc) >= DEBOUNCE_SCANS) begin
                     key_down_d = 1'b0;
                     dcnt_d     = '0;
                     state_d    = ST_IDLE;
                  end
               end else if (scan_single || scan_multi) begin
                  dcnt_d  = '0;
                  state_d = ST_HELD;
               end
            end
            default: begin
               dcnt_d  = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign kp.col       = col_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: column sequence after reset, a table of
// per-scan key patterns with expected outputs, and randomized key patterns
// checked against a scan-level reference model.
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DS        = 3;
   localparam int SCAN_CLKS = 4 * SCAN_DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [15:0] keys = 16'h0;   // pressed keys, bit r*4+c

   always #5 clk = ~clk;

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   // Passive keypad: a pressed key pulls its row low while its column is driven.
   always_comb begin
      kp.row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !kp.col[c]) kp.row[r] = 1'b0;
   end

   int errors = 0;
   int checks = 0;
   int pulses_seen = 0;
   int pulses_exp  = 0;

   always @(negedge clk) if (kp.key_valid === 1'b1) pulses_seen++;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] key(input int r, input int c);
      return 16'(1) << (r*4 + c);
   endfunction

   // Reset for one clock; leaves time at #1 after the reset edge.
   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset col", kp.col, 4'b1110);
      check("reset key_valid", kp.key_valid, 1'b0);
      check("reset key_code", kp.key_code, 4'h0);
      check("reset key_down", kp.key_down, 1'b0);
      rst = 1'b1;
   endtask

   // Present a key pattern for one full scan; returns #1 after scan completion.
   task automatic run_scan(input logic [15:0] k);
      keys = k;
      repeat (SCAN_CLKS) @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (scan level) ----------------
   localparam logic [3:0] MAP [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}};

   bit         m_down;
   logic [3:0] m_code;
   int         m_press_run;     // consecutive identical single-key scans
   logic [3:0] m_run_code;
   int         m_none_run;      // consecutive empty scans

   task automatic model_reset();
      m_down = 0; m_code = 4'h0; m_press_run = 0; m_run_code = 4'h0; m_none_run = 0;
   endtask

   task automatic model_step(input logic [15:0] k, output logic ev);
      int n;
      logic [3:0] code;
      n = $countones(k);
      code = 4'h0;
      ev = 1'b0;
      for (int i = 0; i < 16; i++) if (k[i]) code = MAP[i/4][i%4];
      if (n == 1) begin
         if (m_press_run > 0 && code == m_run_code) m_press_run++;
         else begin m_press_run = 1; m_run_code = code; end
         m_none_run = 0;
      end else if (n == 0) begin
         m_press_run = 0;
         m_none_run++;
      end else begin
         m_press_run = 0;
         m_none_run = 0;
      end
      if (!m_down && n == 1 && m_press_run == DS) begin
         ev = 1'b1; m_code = code; m_down = 1;
      end else if (m_down && m_none_run == DS) begin
         m_down = 0;
      end
   endtask

   typedef struct {
      bit         do_rst;
      logic [15:0] keys;
      logic       exp_valid;
      logic [3:0] exp_code;
      logic       exp_down;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rs, input logic [15:0] k, input logic v, input logic [3:0] c, input logic d);
      vec_t e;
      e.do_rst = rs; e.keys = k; e.exp_valid = v; e.exp_code = c; e.exp_down = d;
      vecs.push_back(e);
   endtask

   initial begin
      logic [15:0] k6, k1, k5, rk;
      logic [3:0]  exp_col;
      logic        ev;
      string       tag;
      k6 = key(1, 2); k1 = key(0, 0); k5 = key(1, 1);

      // Column sequence with no key pressed.
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      keys = 16'h0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         exp_col = ~(4'b0001 << (((n - 1) / SCAN_DIV) % 4));
         check($sformatf("idle col n=%0d", n), kp.col, exp_col);
         check($sformatf("idle key_valid n=%0d", n), kp.key_valid, 1'b0);
      end
      check("idle key_code", kp.key_code, 4'h0);
      check("idle key_down", kp.key_down, 1'b0);

      // Press '6', glitchy release, '1'+'5' multi then '1' alone, release.
      add(1, 16'h0, 0, 4'h0, 0);
      add(0, 16'h0, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, k6, 1, 4'h6, 1);
      add(0, k6, 0, 4'h6, 1);
      add(0, k6, 0, 4'h6, 1);
      add(0, 16'h0, 0, 4'h6, 1);
      add(0, 16'h0, 0, 4'h6, 1);
      add(0, k6, 0, 4'h6, 1);
      add(0, 16'h0, 0, 4'h6, 1);
      add(0, 16'h0, 0, 4'h6, 1);
      add(0, 16'h0, 0, 4'h6, 0);
      for (int i = 0; i < 5; i++) add(0, k1 | k5, 0, 4'h6, 0);
      add(0, k1, 0, 4'h6, 0);
      add(0, k1, 0, 4'h6, 0);
      add(0, k1, 1, 4'h1, 1);
      add(0, 16'h0, 0, 4'h1, 1);
      add(0, 16'h0, 0, 4'h1, 1);
      add(0, 16'h0, 0, 4'h1, 0);
      // Bounce never reaches three clean scans.
      add(1, k6, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, 16'h0, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, 16'h0, 0, 4'h0, 0);
      add(0, 16'h0, 0, 4'h0, 0);
      add(0, 16'h0, 0, 4'h0, 0);
      // Reset while held, key still down afterwards.
      add(1, k6, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, k6, 1, 4'h6, 1);
      add(0, k6, 0, 4'h6, 1);
      add(1, k6, 0, 4'h0, 0);
      add(0, k6, 0, 4'h0, 0);
      add(0, k6, 1, 4'h6, 1);
      add(0, k6, 0, 4'h6, 1);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         run_scan(vecs[i].keys);
         tag = $sformatf("vec%0d", i);
         check({tag, " key_valid"}, kp.key_valid, vecs[i].exp_valid);
         check({tag, " key_code"},  kp.key_code,  vecs[i].exp_code);
         check({tag, " key_down"},  kp.key_down,  vecs[i].exp_down);
         if (vecs[i].exp_valid) pulses_exp++;
      end

      // Randomized key patterns against the scan-level model.
      do_reset();
      model_reset();
      rk = 16'h0;
      for (int s = 0; s < 200; s++) begin
         if ($urandom_range(0, 9) >= 7) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      rk = 16'h0;
            else if (sel < 8) rk = key($urandom_range(0, 3), $urandom_range(0, 3));
            else              rk = key($urandom_range(0, 3), $urandom_range(0, 3))
                                 | key($urandom_range(0, 3), $urandom_range(0, 3));
         end
         run_scan(rk);
         model_step(rk, ev);
         if (ev) pulses_exp++;
         tag = $sformatf("rand%0d", s);
         check({tag, " key_valid"}, kp.key_valid, ev);
         check({tag, " key_code"},  kp.key_code,  m_code);
         check({tag, " key_down"},  kp.key_down,  m_down);
      end

      keys = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("total key_valid pulses", pulses_seen, pulses_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
